// File: rtl/tt_madhu_pkg.sv
// rtl/tt_madhu_pkg.sv - shared types and pin-frame constants for the sequential divider
package tt_madhu_pkg;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // uio bit positions; suffixed so the status index does not clash with state DONE
  localparam int LD_A_BIT  = 0;
  localparam int LD_B_BIT  = 1;
  localparam int START_BIT = 2;
  localparam int RSEL_BIT  = 3;
  localparam int BUSY_BIT  = 4;
  localparam int DONE_BIT  = 5;
  localparam int DBZ_BIT   = 6;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_madhu_sync_edge.sv
// rtl/tt_madhu_sync_edge.sv - multi-stage synchroniser with rising-edge pulse per bit
module tt_madhu_sync_edge #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] prev;

  // shift the asynchronous pins through the chain; prev holds last synced value for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      prev <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[STAGES-1];
    end
  end

  assign q    = stage[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/tt_um_madhu_seq_divider.sv
// rtl/tt_um_madhu_seq_divider.sv - multi-cycle unsigned restoring divider on the TinyTapeout pin frame
module tt_um_madhu_seq_divider
  import tt_madhu_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  state_t state, next_state;

  logic [WIDTH-1:0] a_reg, b_reg, q_reg, r_reg;
  logic [WIDTH-1:0] rem, dvd;
  logic [CNT_W-1:0] cnt;
  logic             dbz;

  logic [2:0] sync_q, sync_rise;

  tt_madhu_sync_edge #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[2:0]),
    .q     (sync_q),
    .rise  (sync_rise)
  );

  logic start_pulse, ld_a, ld_b, running, b_zero, last_step;
  assign start_pulse = sync_rise[START_BIT];
  assign ld_a        = sync_q[LD_A_BIT];
  assign ld_b        = sync_q[LD_B_BIT];
  assign running     = (state == RUN);
  assign b_zero      = (b_reg == '0);
  assign last_step   = (cnt == CNT_W'(WIDTH - 1));

  // one restoring step: shift next dividend bit into the widened remainder, subtract if it fits
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next, dvd_next;
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign fits     = (shifted >= {1'b0, b_reg});
  assign diff     = shifted - {1'b0, b_reg};
  assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_next = {dvd[WIDTH-2:0], fits};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // next state: start is honoured only outside RUN; zero divisor short-circuits to DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_pulse) next_state = b_zero ? DONE : RUN;
      RUN:        if (last_step)   next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // operand loads, division datapath and result capture; Q/R only change when a result is final
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      q_reg <= '0;
      r_reg <= '0;
      rem   <= '0;
      dvd   <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else if (!running) begin
      if (ld_a) a_reg <= ui_in;
      if (ld_b) b_reg <= ui_in;
      if (start_pulse) begin
        if (b_zero) begin
          q_reg <= '1;
          r_reg <= a_reg;
          dbz   <= 1'b1;
        end else begin
          dvd <= a_reg;
          rem <= '0;
          cnt <= '0;
          dbz <= 1'b0;
        end
      end
    end else begin
      rem <= rem_next;
      dvd <= dvd_next;
      cnt <= cnt + CNT_W'(1);
      if (last_step) begin
        q_reg <= dvd_next;
        r_reg <= rem_next;
      end
    end
  end

  // output mux and status pins; rsel is a static strap so it bypasses the synchroniser
  always_comb begin
    uo_out            = uio_in[RSEL_BIT] ? r_reg : q_reg;
    uio_out           = '0;
    uio_out[BUSY_BIT] = running;
    uio_out[DONE_BIT] = (state == DONE);
    uio_out[DBZ_BIT]  = dbz;
    uio_oe            = UIO_OE_MASK;
  end

  logic _unused;
  assign _unused = &{1'b0, ena, uio_in[7:4], sync_q[START_BIT], sync_rise[1:0], diff[WIDTH]};

endmodule

// File: tb/tb_tt_um_madhu_seq_divider.sv
// tb/tb_tt_um_madhu_seq_divider.sv - directed self-checking bench for the sequential divider
module tb_tt_um_madhu_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  tt_um_madhu_seq_divider dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (uio_out[4] && uio_out[5]) overlap++;
  endtask

  task automatic load_a(input logic [7:0] v);
    ui_in = v; uio_in[0] = 1'b1;
    repeat (3) tick();
    uio_in[0] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic load_b(input logic [7:0] v);
    ui_in = v; uio_in[1] = 1'b1;
    repeat (3) tick();
    uio_in[1] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic read_qr(output logic [7:0] q, output logic [7:0] r);
    uio_in[3] = 1'b0; #1 q = uo_out;
    uio_in[3] = 1'b1; #1 r = uo_out;
    uio_in[3] = 1'b0;
  endtask

  task automatic run_op(input bit do_load, input logic [7:0] a, input logic [7:0] b,
                        output int busy_cnt, output int lat,
                        output logic [7:0] q, output logic [7:0] r, output logic dbz);
    if (do_load) begin
      load_a(a);
      load_b(b);
    end
    uio_in[2] = 1'b1;
    busy_cnt = 0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (i == 3) uio_in[2] = 1'b0;
      if (uio_out[4]) busy_cnt++;
      if (i >= 3 && uio_out[5]) lat = i;
    end
    uio_in[2] = 1'b0;
    repeat (2) tick();
    read_qr(q, r);
    dbz = uio_out[6];
  endtask

  task automatic do_vec(input string tag, input bit do_load, input logic [7:0] a, input logic [7:0] b);
    int busy_cnt, lat;
    logic [7:0] q, r, eq, er;
    logic dbz;
    run_op(do_load, a, b, busy_cnt, lat, q, r, dbz);
    if (b == 0) begin
      eq = 8'hFF; er = a;
    end else begin
      eq = a / b; er = a % b;
    end
    check($sformatf("%s.q", tag), q, eq);
    check($sformatf("%s.r", tag), r, er);
    check($sformatf("%s.dbz", tag), dbz, (b == 0));
    check($sformatf("%s.lat", tag), lat, (b == 0) ? 3 : 11);
    check($sformatf("%s.busy", tag), busy_cnt, (b == 0) ? 0 : 8);
    check($sformatf("%s.done", tag), uio_out[5], 1);
  endtask

  logic [7:0] a_list [9] = '{8'd0, 8'd1, 8'd2, 8'd99, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
  logic [7:0] b_list [8] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd128, 8'd200, 8'd255};

  initial begin
    int busy_cnt, lat;
    logic [7:0] q, r;
    logic dbz;
    logic [7:0] tmp;

    rst_n = 1'b0; ena = 1'b1; ui_in = '0; uio_in = '0;
    repeat (3) tick();
    check("rst.uo_out", uo_out, 0);
    check("rst.uio_out", uio_out, 0);
    check("rst.uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    tick();

    do_vec("d100_7", 1'b1, 8'd100, 8'd7);
    do_vec("d255_1", 1'b1, 8'd255, 8'd1);
    do_vec("d5_9", 1'b1, 8'd5, 8'd9);
    do_vec("dbz42", 1'b1, 8'd42, 8'd0);

    // start and ld_a pulsed mid-run must be ignored
    load_a(8'd200);
    load_b(8'd3);
    uio_in[2] = 1'b1;
    repeat (3) tick();
    check("mid.busy", uio_out[4], 1);
    uio_in[2] = 1'b0;
    repeat (2) tick();
    ui_in = 8'd9; uio_in[2] = 1'b1; uio_in[0] = 1'b1;
    repeat (2) tick();
    uio_in[2] = 1'b0; uio_in[0] = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      tick();
      if (uio_out[5]) lat = i;
    end
    check("mid.done_seen", (lat >= 0), 1);
    repeat (3) tick();
    read_qr(q, r);
    check("mid.q", q, 8'd66);
    check("mid.r", r, 8'd2);
    check("mid.dbz", uio_out[6], 0);
    do_vec("mid_rerun", 1'b0, 8'd200, 8'd3);

    // holding start high yields exactly one run
    load_a(8'd77);
    load_b(8'd7);
    uio_in[2] = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uio_out[4]) busy_cnt++;
    end
    uio_in[2] = 1'b0;
    repeat (3) tick();
    read_qr(q, r);
    check("hold.busy", busy_cnt, 8);
    check("hold.done", uio_out[5], 1);
    check("hold.q", q, 8'd11);
    check("hold.r", r, 8'd0);

    // async reset in the middle of a run
    load_a(8'd50);
    load_b(8'd5);
    uio_in[2] = 1'b1;
    repeat (3) tick();
    uio_in[2] = 1'b0;
    repeat (3) tick();
    check("arst.pre_busy", uio_out[4], 1);
    rst_n = 1'b0;
    #1;
    check("arst.uio_out", uio_out, 0);
    check("arst.uio_oe", uio_oe, 8'hF0);
    read_qr(q, r);
    check("arst.q", q, 0);
    check("arst.r", r, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("arst.post_done", uio_out[5], 0);
    do_vec("d60_6", 1'b1, 8'd60, 8'd6);

    // operand sweep across corner values, then zero divisor for every listed A
    foreach (a_list[i]) begin
      foreach (b_list[j]) begin
        do_vec($sformatf("sw%0d_%0d", a_list[i], b_list[j]), 1'b1, a_list[i], b_list[j]);
      end
    end
    foreach (a_list[i]) begin
      tmp = a_list[i];
      do_vec($sformatf("swdbz%0d", tmp), 1'b1, tmp, 8'd0);
    end

    check("busy_done_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
